// File: rtl/jtopl_acc_fifo.sv
// Frame accumulator for the OPL operator slot stream: sums carrier and additive-modulator
// outputs over each 18-slot frame, then saturates and queues the result in a 2-deep FIFO.
module jtopl_acc_fifo #(
   parameter int ACCW = 18,
   parameter int OUTW = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cenop,
   input  logic                   zero,
   input  logic signed [12:0]     op_result,
   input  logic                   op_out,
   input  logic                   con_out,
   output logic signed [OUTW-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   clip,
   output logic                   ovf
);

   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] contrib;
   logic                   primed;
   logic                   fits;
   logic signed [OUTW-1:0] sat_val;
   logic                   push_req;
   logic                   push_ok;
   logic                   pop;
   logic                   full;
   logic signed [OUTW-1:0] mem [2];
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0]             count;
   logic [1:0]             count_next;

   always_comb begin
      contrib = '0;
      if (op_out || con_out)
         contrib = {{(ACCW-13){op_result[12]}}, op_result};
   end

   // The sum fits in OUTW bits when every bit above the output sign bit equals the sign.
   always_comb begin
      fits = (acc[ACCW-1:OUTW-1] == {(ACCW-OUTW+1){acc[ACCW-1]}});
      if (fits)
         sat_val = acc[OUTW-1:0];
      else if (acc[ACCW-1])
         sat_val = {1'b1, {(OUTW-1){1'b0}}};
      else
         sat_val = {1'b0, {(OUTW-1){1'b1}}};
   end

   assign out_valid = (count != 2'd0);
   assign full      = (count == 2'd2);
   assign pop       = out_valid && out_ready;
   assign push_req  = cenop && zero && primed;
   assign push_ok   = push_req && (!full || pop);
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         primed <= 1'b0;
      end else if (cenop) begin
         if (zero) begin
            acc    <= contrib;
            primed <= 1'b1;
         end else begin
            acc <= acc + contrib;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         clip <= push_req && !fits;
         if (push_req && full && !pop)
            ovf <= 1'b1;
      end
   end

   always_comb begin
      case ({push_ok, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok)
            wr_ptr <= !wr_ptr;
         if (pop)
            rd_ptr <= !rd_ptr;
         count <= count_next;
      end
   end

   // When full, wr_ptr equals rd_ptr: a simultaneous push overwrites the entry leaving on this edge.
   for (genvar gi = 0; gi < 2; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            mem[gi] <= '0;
         else if (push_ok && (wr_ptr == 1'(gi)))
            mem[gi] <= sat_val;
      end
   end

endmodule
